vga_layer_compositor: RTL and testbench

- Parametrised video output stage between the VGA scanner and the pins. Replaces the fixed 3-layer priority mux and output flops in the top level.
- Merges NUM_LAYERS sprite/graphic layers over a background colour by fixed priority (layer 0 highest).
- Delays scanner sync/DE to match renderer latency.
- Applies a per-frame layer enable mask.
- Accumulates per-frame overlap (collision) flags between layer 0 and every other layer, for the game logic.

---
 rtl/vga_layer_compositor.sv | 141 ++++++++++++++
 tb/tb_vga_layer_compositor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor.sv
// rtl/vga_layer_compositor.sv - priority layer compositor with sync alignment, frame mask and overlap flags (option: VGA_LAYER_COMPOSITOR_COLORKEY_EN)
module vga_layer_compositor #(
    parameter int                 NUM_LAYERS      = 4,
    parameter int                 COLOR_W         = 16,
    parameter int                 ALIGN_DELAY     = 1,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = 16'hF81F
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_hsync,
    input  logic                          in_vsync,
    input  logic                          in_de,
    input  logic                          new_frame,
    input  logic [NUM_LAYERS-1:0]         layer_mask_in,
    input  logic [NUM_LAYERS-1:0]         layer_pe,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic                          vga_hsync,
    output logic                          vga_vsync,
    output logic                          vga_de,
    output logic [COLOR_W-1:0]            vga_rgb,
    output logic [NUM_LAYERS-1:0]         hit_flags,
    output logic                          hit_valid
);

    logic a_hsync, a_vsync, a_de;

    generate
        if (ALIGN_DELAY == 0) begin : g_nodly
            assign {a_hsync, a_vsync, a_de} = {in_hsync, in_vsync, in_de};
        end else begin : g_dly
            // Stage k holds {hsync, vsync, de} delayed by k+1 cycles.
            logic [2:0] align_q [ALIGN_DELAY];
            logic [2:0] align_d [ALIGN_DELAY];

            always_comb begin
                align_d[0] = {in_hsync, in_vsync, in_de};
                for (int k = 1; k < ALIGN_DELAY; k++) begin
                    align_d[k] = align_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < ALIGN_DELAY; k++) begin
                        align_q[k] <= 3'b000;
                    end
                end else begin
                    for (int k = 0; k < ALIGN_DELAY; k++) begin
                        align_q[k] <= align_d[k];
                    end
                end
            end

            assign {a_hsync, a_vsync, a_de} = align_q[ALIGN_DELAY-1];
        end
    endgenerate

    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [NUM_LAYERS-1:0] hit_flags_q, hit_flags_d;
    logic                  hit_valid_q, hit_valid_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  de_q, de_d;
    logic [COLOR_W-1:0]    rgb_q, rgb_d;

    logic [NUM_LAYERS-1:0] eff;
    logic [NUM_LAYERS-1:0] hit_now;
    logic [COLOR_W-1:0]    sel_color;

    always_comb begin
        eff = layer_pe & mask_q;
`ifdef VGA_LAYER_COMPOSITOR_COLORKEY_EN
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_color[i*COLOR_W +: COLOR_W] == TRANSPARENT_KEY) begin
                eff[i] = 1'b0;
            end
        end
`endif
    end

    // Walk from lowest to highest priority so the lowest effective index lands last.
    always_comb begin
        sel_color = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                sel_color = layer_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        hit_now = '0;
        if (a_de && eff[0]) begin
            hit_now = {eff[NUM_LAYERS-1:1], 1'b0};
        end
    end

    // A hit landing on the closing cycle belongs to the frame being published.
    always_comb begin
        mask_d      = new_frame ? layer_mask_in : mask_q;
        acc_d       = new_frame ? '0 : (acc_q | hit_now);
        hit_flags_d = new_frame ? (acc_q | hit_now) : hit_flags_q;
        hit_valid_d = new_frame;
        hsync_d     = a_hsync;
        vsync_d     = a_vsync;
        de_d        = a_de;
        rgb_d       = a_de ? sel_color : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q      <= '1;
            acc_q       <= '0;
            hit_flags_q <= '0;
            hit_valid_q <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            hit_flags_q <= hit_flags_d;
            hit_valid_q <= hit_valid_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_de    = de_q;
    assign vga_rgb   = rgb_q;
    assign hit_flags = hit_flags_q;
    assign hit_valid = hit_valid_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb/tb_vga_layer_compositor.sv - scoreboard bench for vga_layer_compositor
module tb_vga_layer_compositor;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int D   = 3;
    localparam logic [15:0] KEY = 16'hF81F;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_hsync, in_vsync, in_de, new_frame;
    logic [N-1:0]  layer_mask_in, layer_pe;
    logic [CW-1:0] lc [N];
    logic [N*CW-1:0] layer_color;
    logic [CW-1:0] bg_color;
    logic          vga_hsync, vga_vsync, vga_de, hit_valid;
    logic [CW-1:0] vga_rgb;
    logic [N-1:0]  hit_flags;

    assign layer_color = {lc[3], lc[2], lc[1], lc[0]};

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .NUM_LAYERS(N), .COLOR_W(CW), .ALIGN_DELAY(D), .TRANSPARENT_KEY(KEY)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .new_frame(new_frame), .layer_mask_in(layer_mask_in),
        .layer_pe(layer_pe), .layer_color(layer_color), .bg_color(bg_color),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .hit_flags(hit_flags), .hit_valid(hit_valid)
    );

    typedef struct {
        logic        hs, vs, de;
        logic [15:0] rgb;
        logic [3:0]  flags;
        logic        valid;
    } exp_t;

    exp_t       sb [$];
    logic [2:0] hist [$];
    logic [3:0] mask_m, acc_m, flags_m;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(3'b000);
        mask_m  = 4'hF;
        acc_m   = 4'h0;
        flags_m = 4'h0;
    endtask

    // Predict the outputs registered at the coming edge, then advance one cycle.
    task automatic tick();
        logic [2:0]  a;
        logic [3:0]  eff;
        logic [15:0] sel;
        logic        found;
        exp_t        e;
        hist.push_back({in_hsync, in_vsync, in_de});
        a   = hist.pop_front();
        eff = layer_pe & mask_m;
`ifdef VGA_LAYER_COMPOSITOR_COLORKEY_EN
        for (int i = 0; i < N; i++) if (lc[i] == KEY) eff[i] = 1'b0;
`endif
        sel   = bg_color;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && eff[i]) begin
                sel   = lc[i];
                found = 1'b1;
            end
        end
        e.hs  = a[2];
        e.vs  = a[1];
        e.de  = a[0];
        e.rgb = a[0] ? sel : 16'h0000;
        if (a[0] && eff[0]) acc_m = acc_m | (eff & 4'b1110);
        e.valid = new_frame;
        if (new_frame) begin
            flags_m = acc_m;
            acc_m   = 4'h0;
            mask_m  = layer_mask_in;
        end
        e.flags = flags_m;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("hsync", vga_hsync, e.hs);
            check_eq("vsync", vga_vsync, e.vs);
            check_eq("de", vga_de, e.de);
            check_eq("rgb", vga_rgb, e.rgb);
            check_eq("hit_flags", hit_flags, e.flags);
            check_eq("hit_valid", hit_valid, e.valid);
        end
    end

    initial begin
        rstn = 1'b0;
        in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b1; new_frame = 1'b0;
        layer_mask_in = 4'hF; layer_pe = 4'hF; bg_color = 16'h1234;
        lc[0] = 16'hF800; lc[1] = 16'h07E0; lc[2] = 16'h001F; lc[3] = 16'hFFFF;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_rgb", vga_rgb, 0);
            check_eq("rst_de", vga_de, 0);
            check_eq("rst_hs", vga_hsync, 0);
            check_eq("rst_hit", hit_flags, 0);
            check_eq("rst_hv", hit_valid, 0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;

        // First de pixel after release, background only.
        layer_pe = 4'h0;
        repeat (6) tick();

        // Open a frame with everything enabled.
        new_frame = 1'b1; layer_mask_in = 4'hF; tick(); new_frame = 1'b0;

        // Priority: L1 beats L2; no layer gives background; de low gives zero.
        layer_pe = 4'b0110; repeat (2) tick();
        layer_pe = 4'b0000; tick();
        layer_pe = 4'b1111;
        in_de = 1'b0; repeat (D + 2) tick();
        in_de = 1'b1; repeat (D) tick();

        // Mid-frame mask change is ignored until the next frame.
        layer_mask_in = 4'b1101; layer_pe = 4'b0010; repeat (2) tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        repeat (2) tick();
        layer_mask_in = 4'hF; new_frame = 1'b1; tick(); new_frame = 1'b0;

        // One overlap pixel L0/L2, then a clean frame, then back-to-back closes.
        layer_pe = 4'b0000; repeat (2) tick();
        layer_pe = 4'b0101; tick();
        layer_pe = 4'b0000; repeat (2) tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        layer_pe = 4'b0001; repeat (3) tick();
        new_frame = 1'b1; tick(); tick(); tick(); new_frame = 1'b0;
        tick();

        // Single-cycle hsync/vsync pulses through the alignment line.
        in_hsync = 1'b1; tick(); in_hsync = 1'b0; tick();
        in_vsync = 1'b1; repeat (2) tick(); in_vsync = 1'b0;
        repeat (D + 2) tick();

        // Transparent-key colour on L0 over L1.
        lc[0] = KEY; layer_pe = 4'b0011; repeat (2) tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        tick();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            in_hsync      = ($urandom_range(0, 15) == 0);
            in_vsync      = ($urandom_range(0, 31) == 0);
            in_de         = ($urandom_range(0, 3) != 0);
            new_frame     = ($urandom_range(0, 19) == 0);
            layer_mask_in = 4'($urandom_range(0, 15));
            layer_pe      = 4'($urandom_range(0, 15));
            bg_color      = 16'($urandom);
            for (int i = 0; i < N; i++) lc[i] = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
            tick();
        end
        in_hsync = 1'b0; in_vsync = 1'b0; new_frame = 1'b0;

        // Publish a hit, keep pixels flowing, then reset mid-frame.
        in_de = 1'b1; layer_mask_in = 4'hF;
        lc[0] = 16'hF800; lc[1] = 16'h07E0; lc[2] = 16'h001F; lc[3] = 16'hFFFF;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        layer_pe = 4'b1001; repeat (D + 1) tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        layer_pe = 4'b0011; repeat (2) tick();
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_rgb", vga_rgb, 0);
        check_eq("mid_rst_de", vga_de, 0);
        check_eq("mid_rst_hit", hit_flags, 0);
        check_eq("mid_rst_hv", hit_valid, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        layer_pe = 4'b0000; repeat (D + 2) tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        repeat (2) tick();

        @(negedge clk); #1;
        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
